lc4_regfile_ss: RTL and testbench

//  Two-wide register file for the superscalar LC4 datapath; sits directly upstream of the two ALUs.

---
 rtl/lc4_ss_pkg.sv | 9 +
 rtl/lc4_ss_reg_cell.sv | 24 ++
 rtl/lc4_regfile_ss.sv | 81 ++++++++
 tb/tb_lc4_regfile_ss.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc4_ss_pkg.sv
// Shared LC4 superscalar constants used by the register file, decode and
// the dependence/stall logic.
package lc4_ss_pkg;

  localparam int unsigned LC4_NREG      = 8;
  localparam int unsigned LC4_REG_SEL_W = 3;
  localparam int unsigned LC4_WORD_W    = 16;

endpackage

// File: rtl/lc4_ss_reg_cell.sv
// One architectural register: async active-high clear, gated parallel load.
module lc4_ss_reg_cell #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/lc4_regfile_ss.sv
// Two-wide LC4 register file: 4 combinational read ports with write-before-read
// bypass, 2 write ports where the younger pipe B wins a same-register conflict.
module lc4_regfile_ss
  import lc4_ss_pkg::*;
#(
  parameter int unsigned n    = LC4_WORD_W,
  parameter int unsigned NREG = LC4_NREG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    gwe,
  input  logic [$clog2(NREG)-1:0] i_rs_A,
  output logic [n-1:0]            o_rs_data_A,
  input  logic [$clog2(NREG)-1:0] i_rt_A,
  output logic [n-1:0]            o_rt_data_A,
  input  logic [$clog2(NREG)-1:0] i_rs_B,
  output logic [n-1:0]            o_rs_data_B,
  input  logic [$clog2(NREG)-1:0] i_rt_B,
  output logic [n-1:0]            o_rt_data_B,
  input  logic [$clog2(NREG)-1:0] i_rd_A,
  input  logic [n-1:0]            i_wdata_A,
  input  logic                    i_rd_we_A,
  input  logic [$clog2(NREG)-1:0] i_rd_B,
  input  logic [n-1:0]            i_wdata_B,
  input  logic                    i_rd_we_B
);

  localparam int unsigned SelW   = $clog2(NREG);
  localparam int unsigned NPorts = 4;

  logic [NREG-1:0][n-1:0]     reg_val;
  logic [NPorts-1:0][SelW-1:0] rd_sel;
  logic [NPorts-1:0][n-1:0]    rd_data;

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    logic hit_a, hit_b;

    assign hit_a = i_rd_we_A && (i_rd_A == SelW'(r));
    assign hit_b = i_rd_we_B && (i_rd_B == SelW'(r));

    // B is younger, so its data wins when both pipes target this register.
    lc4_ss_reg_cell #(
      .Width(n)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .en_i (gwe && (hit_a || hit_b)),
      .d_i  (hit_b ? i_wdata_B : i_wdata_A),
      .q_o  (reg_val[r])
    );
  end

  assign rd_sel = {i_rt_B, i_rs_B, i_rt_A, i_rs_A};

  for (genvar p = 0; p < NPorts; p++) begin : g_rd
    logic [n-1:0] port_data;

    // Bypass order mirrors the write conflict rule, so the read value always
    // equals what the array will hold after the edge.
    always_comb begin
      port_data = reg_val[rd_sel[p]];
      if (gwe && i_rd_we_A && (rd_sel[p] == i_rd_A)) begin
        port_data = i_wdata_A;
      end
      if (gwe && i_rd_we_B && (rd_sel[p] == i_rd_B)) begin
        port_data = i_wdata_B;
      end
      if (rst) begin
        port_data = '0;
      end
    end

    assign rd_data[p] = port_data;
  end

  assign o_rs_data_A = rd_data[0];
  assign o_rt_data_A = rd_data[1];
  assign o_rs_data_B = rd_data[2];
  assign o_rt_data_B = rd_data[3];

endmodule

// File: tb/tb_lc4_regfile_ss.sv
// Self-checking bench for lc4_regfile_ss: directed scenarios plus randomized
// traffic against an array model of the architectural registers.
module tb_lc4_regfile_ss;

  logic        clk = 1'b0;
  logic        rst;
  logic        gwe;
  logic [2:0]  sel [4];
  logic [2:0]  rd_a, rd_b;
  logic [15:0] wd_a, wd_b;
  logic        we_a, we_b;
  wire  [15:0] obs [4];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] model [8];

  always #5 clk = ~clk;

  lc4_regfile_ss dut (
    .clk         (clk),
    .rst         (rst),
    .gwe         (gwe),
    .i_rs_A      (sel[0]),
    .o_rs_data_A (obs[0]),
    .i_rt_A      (sel[1]),
    .o_rt_data_A (obs[1]),
    .i_rs_B      (sel[2]),
    .o_rs_data_B (obs[2]),
    .i_rt_B      (sel[3]),
    .o_rt_data_B (obs[3]),
    .i_rd_A      (rd_a),
    .i_wdata_A   (wd_a),
    .i_rd_we_A   (we_a),
    .i_rd_B      (rd_b),
    .i_wdata_B   (wd_b),
    .i_rd_we_B   (we_b)
  );

  // Reference: a read shows what the register will hold after this edge.
  function automatic logic [15:0] expect_rd(input logic [2:0] s);
    logic [15:0] post [8];
    if (rst) return 16'h0000;
    post = model;
    if (gwe && we_a) post[rd_a] = wd_a;
    if (gwe && we_b) post[rd_b] = wd_b;
    return post[s];
  endfunction

  task automatic clear_model();
    for (int m = 0; m < 8; m++) model[m] = 16'h0000;
  endtask

  task automatic idle();
    gwe  = 1'b1;
    we_a = 1'b0;
    we_b = 1'b0;
    rd_a = 3'd0;
    rd_b = 3'd0;
    wd_a = 16'h0000;
    wd_b = 16'h0000;
  endtask

  task automatic set_sel_all(input logic [2:0] s);
    for (int p = 0; p < 4; p++) sel[p] = s;
  endtask

  // Clock edge with model update; returns at the following negedge.
  task automatic commit();
    @(posedge clk);
    if (rst) begin
      clear_model();
    end else if (gwe) begin
      if (we_a) model[rd_a] = wd_a;
      if (we_b) model[rd_b] = wd_b;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rd_a = 3'd3; wd_a = 16'h1234; we_a = 1'b1;
    commit();
    idle();
    rst = 1'b1;
    clear_model();
    rd_b = 3'd3; wd_b = 16'hFFFF; we_b = 1'b1;
    for (int s = 0; s < 8; s++) begin
      set_sel_all(3'(s));
      #1;
      for (int p = 0; p < 4; p++) begin
        n_tests++;
        if (obs[p] !== 16'h0000) begin
          n_fail++;
          $display("FAIL reset_hold port%0d sel%0d: got %h want 0000", p, s, obs[p]);
        end
      end
    end
    commit();
    rst = 1'b0;
    idle();
    for (int s = 0; s < 8; s++) begin
      set_sel_all(3'(s));
      #1;
      for (int p = 0; p < 4; p++) begin
        n_tests++;
        if (obs[p] !== 16'h0000) begin
          n_fail++;
          $display("FAIL reset_after port%0d sel%0d: got %h want 0000", p, s, obs[p]);
        end
      end
    end
  endtask

  task automatic test_dual_write();
    idle();
    rd_a = 3'd1; wd_a = 16'hAAAA; we_a = 1'b1;
    rd_b = 3'd2; wd_b = 16'h5555; we_b = 1'b1;
    commit();
    idle();
    sel[0] = 3'd1; sel[3] = 3'd2; sel[1] = 3'd2; sel[2] = 3'd1;
    #1;
    n_tests++;
    if (obs[0] !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL dual_rs_A: got %h want AAAA", obs[0]);
    end
    n_tests++;
    if (obs[3] !== 16'h5555) begin
      n_fail++;
      $display("FAIL dual_rt_B: got %h want 5555", obs[3]);
    end
    n_tests++;
    if (obs[1] !== 16'h5555 || obs[2] !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL dual_cross: got %h/%h want 5555/AAAA", obs[1], obs[2]);
    end
  endtask

  task automatic test_conflict();
    idle();
    rd_a = 3'd4; wd_a = 16'h0001; we_a = 1'b1;
    rd_b = 3'd4; wd_b = 16'h0002; we_b = 1'b1;
    set_sel_all(3'd4);
    #1;
    for (int p = 0; p < 4; p++) begin
      n_tests++;
      if (obs[p] !== 16'h0002) begin
        n_fail++;
        $display("FAIL conflict_bypass port%0d: got %h want 0002", p, obs[p]);
      end
    end
    commit();
    idle();
    #1;
    for (int p = 0; p < 4; p++) begin
      n_tests++;
      if (obs[p] !== 16'h0002) begin
        n_fail++;
        $display("FAIL conflict_stored port%0d: got %h want 0002", p, obs[p]);
      end
    end
  endtask

  task automatic test_bypass();
    idle();
    rd_a = 3'd5; wd_a = 16'h00FF; we_a = 1'b1;
    commit();
    idle();
    rd_a = 3'd5; wd_a = 16'hBEEF; we_a = 1'b1;
    set_sel_all(3'd5);
    #1;
    for (int p = 0; p < 4; p++) begin
      n_tests++;
      if (obs[p] !== 16'hBEEF) begin
        n_fail++;
        $display("FAIL bypass_on port%0d: got %h want BEEF", p, obs[p]);
      end
    end
    we_a = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) begin
      n_tests++;
      if (obs[p] !== 16'h00FF) begin
        n_fail++;
        $display("FAIL bypass_off port%0d: got %h want 00FF", p, obs[p]);
      end
    end
    commit();
  endtask

  task automatic test_gwe_off();
    idle();
    gwe = 1'b0;
    rd_a = 3'd6; wd_a = 16'hCAFE; we_a = 1'b1;
    set_sel_all(3'd6);
    #1;
    for (int p = 0; p < 4; p++) begin
      n_tests++;
      if (obs[p] !== 16'h0000) begin
        n_fail++;
        $display("FAIL gwe_off_read port%0d: got %h want 0000", p, obs[p]);
      end
    end
    commit();
    idle();
    #1;
    n_tests++;
    if (obs[0] !== 16'h0000) begin
      n_fail++;
      $display("FAIL gwe_off_hold: got %h want 0000", obs[0]);
    end
  endtask

  task automatic test_async_reset();
    idle();
    rd_b = 3'd7; wd_b = 16'h7777; we_b = 1'b1;
    set_sel_all(3'd7);
    #1;
    n_tests++;
    if (obs[2] !== 16'h7777) begin
      n_fail++;
      $display("FAIL async_pre_bypass: got %h want 7777", obs[2]);
    end
    #1;
    rst = 1'b1;
    clear_model();
    #1;
    for (int p = 0; p < 4; p++) begin
      n_tests++;
      if (obs[p] !== 16'h0000) begin
        n_fail++;
        $display("FAIL async_immediate port%0d: got %h want 0000", p, obs[p]);
      end
    end
    commit();
    rst = 1'b0;
    we_b = 1'b0;
    #1;
    n_tests++;
    if (obs[3] !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_r7_cleared: got %h want 0000", obs[3]);
    end
    wd_b = 16'h1357; we_b = 1'b1;
    commit();
    idle();
    #1;
    n_tests++;
    if (obs[1] !== 16'h1357) begin
      n_fail++;
      $display("FAIL async_post_write: got %h want 1357", obs[1]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      gwe  = ($urandom_range(0, 4) != 0);
      we_a = 1'($urandom);
      we_b = 1'($urandom);
      rd_a = 3'($urandom);
      // Bias B toward A's target to hit the conflict case often.
      rd_b = ($urandom_range(0, 3) == 0) ? rd_a : 3'($urandom);
      wd_a = 16'($urandom);
      wd_b = 16'($urandom);
      for (int p = 0; p < 4; p++) begin
        sel[p] = ($urandom_range(0, 2) == 0) ? rd_b : 3'($urandom);
      end
      #1;
      for (int p = 0; p < 4; p++) begin
        n_tests++;
        if (obs[p] !== expect_rd(sel[p])) begin
          n_fail++;
          $display("FAIL random it%0d port%0d sel%0d: got %h want %h",
                   it, p, sel[p], obs[p], expect_rd(sel[p]));
        end
      end
      commit();
    end
    idle();
    for (int s = 0; s < 8; s++) begin
      set_sel_all(3'(s));
      #1;
      n_tests++;
      if (obs[0] !== model[s]) begin
        n_fail++;
        $display("FAIL random_final sel%0d: got %h want %h", s, obs[0], model[s]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    set_sel_all(3'd0);
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_dual_write();
    test_conflict();
    test_bypass();
    test_gwe_off();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
